// File: rtl/ncpu32k_pipe_skid_pkg.sv
// Shared widths and state encoding for the ncpu32k skid-buffered pipeline stage.
package ncpu32k_pipe_skid_pkg;

    localparam int unsigned SKID_DW      = 32;
    localparam int unsigned SKID_STATE_W = 2;

    // Bit 1 is IN_READY and bit 0 is OUT_VALID, so both handshake outputs are flop bits.
    // 2'b00 is the only illegal encoding.
    typedef enum logic [SKID_STATE_W-1:0] {
        SKID_FULL  = 2'b01,
        SKID_EMPTY = 2'b10,
        SKID_BUSY  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/ncpu32k_cell_dff_lr.sv
// D flip-flop bank with synchronous active-low reset and load enable.
module ncpu32k_cell_dff_lr #(
    parameter int unsigned       DW         = 1,
    parameter logic [DW-1:0]     RST_VECTOR = '0
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            q_o <= RST_VECTOR;
        end else if (we_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ncpu32k_pipe_skid.sv
// One pipeline register stage with a skid register: full throughput, IN_READY straight
// from a flop, and no combinational OUT_READY -> IN_READY path.
module ncpu32k_pipe_skid
    import ncpu32k_pipe_skid_pkg::*;
#(
    parameter int unsigned   DW         = SKID_DW,
    parameter logic [DW-1:0] RST_VECTOR = '0
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    logic [SKID_STATE_W-1:0] state_q;
    logic [SKID_STATE_W-1:0] state_d;
    logic [DW-1:0]           main_q;
    logic [DW-1:0]           main_d;
    logic [DW-1:0]           skid_q;
    logic                    main_we_c;
    logic                    skid_we_c;
    logic                    acc_in_c;
    logic                    acc_out_c;

    assign in_ready_o  = state_q[1];
    assign out_valid_o = state_q[0];
    assign out_data_o  = main_q;

    assign acc_in_c  = in_valid_i & in_ready_o;
    assign acc_out_c = out_valid_o & out_ready_i;

    // Next-state and data-register load enables
    always_comb begin
        state_d   = state_q;
        main_d    = in_data_i;
        main_we_c = 1'b0;
        skid_we_c = 1'b0;

        case (state_q)
            SKID_EMPTY: begin
                if (acc_in_c) begin
                    state_d   = SKID_BUSY;
                    main_we_c = 1'b1;
                end
            end
            SKID_BUSY: begin
                if (acc_in_c && acc_out_c) begin
                    main_we_c = 1'b1;
                end else if (acc_in_c) begin
                    state_d   = SKID_FULL;
                    skid_we_c = 1'b1;
                end else if (acc_out_c) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (acc_out_c) begin
                    state_d   = SKID_BUSY;
                    main_d    = skid_q;
                    main_we_c = 1'b1;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase

        // Flush only clears occupancy; payload registers keep their contents
        if (flush_i) begin
            state_d   = SKID_EMPTY;
            main_we_c = 1'b0;
            skid_we_c = 1'b0;
        end
    end

    ncpu32k_cell_dff_lr #(
        .DW         (SKID_STATE_W),
        .RST_VECTOR (SKID_EMPTY)
    ) u_state (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (1'b1),
        .d_i     (state_d),
        .q_o     (state_q)
    );

    ncpu32k_cell_dff_lr #(
        .DW         (DW),
        .RST_VECTOR (RST_VECTOR)
    ) u_main (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (main_we_c),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    ncpu32k_cell_dff_lr #(
        .DW         (DW),
        .RST_VECTOR (RST_VECTOR)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (skid_we_c),
        .d_i     (in_data_i),
        .q_o     (skid_q)
    );

`ifdef NCPU_ENABLE_ASSERT
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            if ($isunknown(in_valid_i)) $fatal(1, "ncpu32k_pipe_skid: in_valid_i is X");
            if ($isunknown(out_ready_i)) $fatal(1, "ncpu32k_pipe_skid: out_ready_i is X");
            if (state_q == SKID_STATE_W'(0)) $fatal(1, "ncpu32k_pipe_skid: illegal state");
        end
    end
`endif

endmodule
